// File: rtl/mips_run_pkg.sv
// Shared definitions for the MIPS run controller: FSM state encoding and
// the default instruction word that marks an explicit program halt.
package mips_run_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } run_state_t;

  // beq $0,$0,-1 : a branch onto itself, the conventional "stop here" word
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h1000_ffff;

endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: stretches reset, enables the
// core, counts cycles/instructions and stops on halt, stalled PC or timeout.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned STALL_LIMIT  = 4,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  output logic                 core_reset,
  output logic                 core_en,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [PC_WIDTH-1:0]  halt_pc,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_LIMIT) + 1;

  localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] CYCLE_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

  run_state_t          state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [PC_WIDTH-1:0] prev_pc;
  logic [STALL_W-1:0]  stall_cnt;
  logic                first_run;

  logic in_run;
  logic pc_same;
  logic halt_hit;
  logic limit_hit;

  assign in_run    = (state == RUN);
  assign pc_same   = (pc == prev_pc);
  assign halt_hit  = (instr_valid && (instr == HALT_INSTR)) ||
                     ((stall_cnt == STALL_LAST) && pc_same);
  assign limit_hit = (cycle_count == CYCLE_LAST);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (in_run),
    .q     (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (in_run && instr_valid),
    .q     (instr_count)
  );

  // prev_pc is meaningless on the first RUN cycle, so that cycle never counts as a repeat
  sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (in_run && (first_run || !pc_same)),
    .inc   (in_run && !first_run && pc_same),
    .q     (stall_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      first_run  <= 1'b1;
      prev_pc    <= '0;
      core_reset <= 1'b1;
      core_en    <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      halt_pc    <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            core_en    <= 1'b1;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          prev_pc   <= pc;
          first_run <= 1'b0;
          // halt is tested first so a halt on the last allowed cycle is not a timeout
          if (halt_hit) begin
            state   <= HALTED;
            done    <= 1'b1;
            halt_pc <= pc;
            core_en <= 1'b0;
            running <= 1'b0;
          end else if (limit_hit) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
            core_en <= 1'b0;
            running <= 1'b0;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed and random programs checked against a
// per-run outcome model (where the run ends, why, and what was counted).
module tb_mips_run_ctrl;

  localparam int RC = 2;
  localparam int MC = 16;
  localparam int SL = 4;
  localparam logic [31:0] HALT = 32'h1000_ffff;
  localparam logic [31:0] ADDI = 32'h2008_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        core_reset, core_en, running, done, timeout;
  logic [31:0] halt_pc, cycle_count, instr_count;

  logic       sc_reset = 1'b1;
  logic       sc_clr = 1'b0;
  logic       sc_inc = 1'b0;
  logic [2:0] sc_q;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] pcv  [MC];
  logic [31:0] insv [MC];
  logic        vv   [MC];

  mips_run_ctrl #(
    .RESET_CYCLES (RC),
    .MAX_CYCLES   (MC),
    .STALL_LIMIT  (SL),
    .PC_WIDTH     (32),
    .CNT_WIDTH    (32),
    .HALT_INSTR   (HALT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .core_reset  (core_reset),
    .core_en     (core_en),
    .running     (running),
    .done        (done),
    .timeout     (timeout),
    .halt_pc     (halt_pc),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  sat_counter #(.WIDTH(3)) sc (
    .clk   (clk),
    .reset (sc_reset),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .q     (sc_q)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] p,
                               input logic [31:0] ins, input logic v);
    reset       = r;
    pc          = p;
    instr       = ins;
    instr_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string where);
    checkOutput({where, "_core_reset"}, 32'(core_reset), 32'd1);
    checkOutput({where, "_core_en"}, 32'(core_en), 32'd0);
    checkOutput({where, "_running"}, 32'(running), 32'd0);
    checkOutput({where, "_done"}, 32'(done), 32'd0);
    checkOutput({where, "_timeout"}, 32'(timeout), 32'd0);
    checkOutput({where, "_halt_pc"}, halt_pc, 32'd0);
    checkOutput({where, "_cycle_count"}, cycle_count, 32'd0);
    checkOutput({where, "_instr_count"}, instr_count, 32'd0);
  endtask

  // Hold reset n cycles, then expect exactly RC low-reset edges before RUN
  task automatic bringUp(input int n);
    int edges;
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, $urandom, $urandom, 1'b1);
      checkResetState("reset");
    end
    edges = 0;
    while (running !== 1'b1 && edges < 10) begin
      applyStimulus(1'b0, 32'h0000_3000 + 32'(4 * edges), HALT, 1'b0);
      edges++;
      if (running !== 1'b1) checkOutput("hold_core_reset", 32'(core_reset), 32'd1);
    end
    checkOutput("hold_length", 32'(edges), 32'(RC));
    checkOutput("run0_core_reset", 32'(core_reset), 32'd0);
    checkOutput("run0_core_en", 32'(core_en), 32'd1);
    checkOutput("run0_cycle_count", cycle_count, 32'd0);
    checkOutput("run0_instr_count", instr_count, 32'd0);
  endtask

  // Model: the run ends at the first cycle holding a valid halt word or closing a
  // window of SL+1 equal PCs; otherwise it times out on RUN cycle MC-1.
  task automatic runProgram(input string name, input int freeze);
    int e;
    bit halted;
    bit stall;
    int sum;
    logic [31:0] exp_pc;
    e = MC - 1;
    halted = 1'b0;
    for (int i = 0; i < MC; i++) begin
      stall = (i >= SL);
      for (int j = 1; j <= SL; j++)
        if (i - j >= 0 && pcv[i - j] != pcv[i]) stall = 1'b0;
      if ((vv[i] && insv[i] == HALT) || stall) begin
        e = i;
        halted = 1'b1;
        break;
      end
    end
    exp_pc = halted ? pcv[e] : 32'd0;
    sum = 0;
    for (int i = 0; i <= e; i++) begin
      checkOutput({name, "_running"}, 32'(running), 32'd1);
      checkOutput({name, "_cycle_count"}, cycle_count, 32'(i));
      checkOutput({name, "_instr_count"}, instr_count, 32'(sum));
      applyStimulus(1'b0, pcv[i], insv[i], vv[i]);
      sum += int'(vv[i]);
    end
    checkOutput({name, "_done"}, 32'(done), 32'(halted));
    checkOutput({name, "_timeout"}, 32'(timeout), 32'(!halted));
    checkOutput({name, "_halt_pc"}, halt_pc, exp_pc);
    checkOutput({name, "_end_cycles"}, cycle_count, 32'(e + 1));
    checkOutput({name, "_end_instrs"}, instr_count, 32'(sum));
    checkOutput({name, "_end_core_en"}, 32'(core_en), 32'd0);
    checkOutput({name, "_end_core_reset"}, 32'(core_reset), 32'd0);
    checkOutput({name, "_end_running"}, 32'(running), 32'd0);
    for (int k = 0; k < freeze; k++) begin
      applyStimulus(1'b0, $urandom, HALT, 1'b1);
      checkOutput({name, "_frz_done"}, 32'(done), 32'(halted));
      checkOutput({name, "_frz_timeout"}, 32'(timeout), 32'(!halted));
      checkOutput({name, "_frz_halt_pc"}, halt_pc, exp_pc);
      checkOutput({name, "_frz_cycles"}, cycle_count, 32'(e + 1));
      checkOutput({name, "_frz_instrs"}, instr_count, 32'(sum));
      checkOutput({name, "_frz_core_en"}, 32'(core_en), 32'd0);
    end
  endtask

  initial begin
    $display("[TB] start");

    // Saturating counter on its own: climbs to 7, sticks, clr beats inc
    @(posedge clk);
    #1;
    checkOutput("sat_reset", 32'(sc_q), 32'd0);
    sc_reset = 1'b0;
    sc_inc   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("sat_count", 32'(sc_q), 32'((k < 7) ? k : 7));
    end
    sc_clr = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("sat_clr", 32'(sc_q), 32'd0);
    sc_clr = 1'b0;
    sc_inc = 1'b0;

    // Explicit halt word at pc 0x3028 after ten ordinary instructions
    bringUp(3);
    for (int i = 0; i < MC; i++) begin
      pcv[i]  = 32'h0000_3000 + 32'(4 * i);
      vv[i]   = (i <= 10);
      insv[i] = (i == 10) ? HALT : ADDI;
    end
    runProgram("halt_word", 20);

    // PC parks at 0x3010 without a halt word
    bringUp(1);
    for (int i = 0; i < MC; i++) begin
      pcv[i]  = (i < 4) ? 32'h0000_3000 + 32'(4 * i) : 32'h0000_3010;
      vv[i]   = 1'b0;
      insv[i] = ADDI;
    end
    runProgram("stall", 5);

    // Ever-changing PC runs into the cycle limit
    bringUp(1);
    for (int i = 0; i < MC; i++) begin
      pcv[i]  = 32'h0000_4000 + 32'(8 * i);
      vv[i]   = 1'($urandom_range(0, 1));
      insv[i] = ADDI;
    end
    runProgram("timeout", 5);

    // Halt word on the very cycle the limit is reached
    bringUp(1);
    for (int i = 0; i < MC; i++) begin
      pcv[i]  = 32'h0000_5000 + 32'(4 * i);
      vv[i]   = (i == MC - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      insv[i] = (i == MC - 1) ? HALT : ADDI;
    end
    runProgram("halt_vs_timeout", 3);

    // Reset pulse in the middle of a run
    bringUp(1);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 32'h0000_3000 + 32'(4 * i), ADDI, 1'b1);
    checkOutput("midrun_cycle_count", cycle_count, 32'd7);
    bringUp(1);

    // Random programs with frequent PC repeats and occasional halt words
    for (int r = 0; r < 8; r++) begin
      if (r != 0) bringUp(1 + int'($urandom_range(0, 1)));
      pcv[0] = 32'h0000_3000 + 32'(4 * $urandom_range(0, 7));
      for (int i = 1; i < MC; i++)
        pcv[i] = ($urandom_range(0, 3) != 0) ? pcv[i - 1]
                                              : 32'h0000_3000 + 32'(4 * $urandom_range(0, 7));
      for (int i = 0; i < MC; i++) begin
        vv[i]   = 1'($urandom_range(0, 1));
        insv[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      end
      runProgram("random", 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised run controller for the single-cycle MIPS core. Replaces the fixed-delay reset/clock stimulus with synthesizable control.
- Stretches reset to the core for a configurable number of cycles, then enables the core.
- Counts cycles and retired instructions.
- Detects program end (halt instruction or stalled PC) and run-away programs (timeout).
- Sits between the board/bench clock-reset source and the mips top; its status outputs drive bench checks or LEDs.

Parameters:
- RESET_CYCLES, 2, cycles core_reset stays high after external reset falls (>=1)
- MAX_CYCLES, 100000, run cycles before timeout is declared (>=2)
- STALL_LIMIT, 4, consecutive cycles with unchanged PC that count as halt (>=2)
- PC_WIDTH, 32, width of pc input and halt_pc output
- CNT_WIDTH, 32, width of cycle_count and instr_count
- HALT_INSTR, 32'h1000_ffff, instruction word treated as explicit halt (beq $0,$0,-1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- pc  in  PC_WIDTH  current core PC
- instr  in  32  instruction fetched at pc
- instr_valid  in  1  core retires instr this cycle
- core_reset  out  1  reset to mips core
- core_en  out  1  core clock-enable; high only in RUN
- running  out  1  state==RUN
- done  out  1  halted normally (sticky)
- timeout  out  1  MAX_CYCLES reached (sticky)
- halt_pc  out  PC_WIDTH  PC at halt detection
- cycle_count  out  CNT_WIDTH  cycles spent in RUN
- instr_count  out  CNT_WIDTH  instructions retired in RUN

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=HOLD, hold_cnt=0, core_reset=1, core_en=0, running=0, done=0, timeout=0, halt_pc=0, cycle_count=0, instr_count=0, stall_cnt=0, prev_pc=0.
- States: HOLD, RUN, HALTED, TIMEOUT. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- HOLD:
  - core_reset=1.
  - hold_cnt increments each cycle with reset=0.
  - When hold_cnt==RESET_CYCLES-1, next state is RUN.
  - core_reset is therefore high for exactly RESET_CYCLES cycles after the first edge with reset=0.
- RUN:
  - core_reset=0, core_en=1, running=1.
  - cycle_count increments every cycle.
  - instr_count increments when instr_valid=1.
  - Both counters saturate at all-ones and never wrap.
  - prev_pc<=pc each cycle.
  - stall_cnt increments when pc==prev_pc and clears otherwise. The first RUN cycle always clears it.
- Halt condition, checked in RUN:
  - Trigger: (instr_valid && instr==HALT_INSTR) or stall_cnt==STALL_LIMIT-1 with pc==prev_pc.
  - Action: next state HALTED, done<=1, halt_pc<=pc.
- Timeout condition, checked in RUN: cycle_count==MAX_CYCLES-1 with no halt that cycle. Action: next state TIMEOUT, timeout<=1.
- Simultaneous halt and timeout: halt wins. done=1, timeout=0.
- HALTED and TIMEOUT:
  - Terminal until reset.
  - core_en=0, core_reset=0, so the core state is preserved for inspection.
  - Counters and halt_pc are frozen. done and timeout never both 1.
- Reset mid-run or in a terminal state: on the next edge everything returns to reset values and the HOLD sequence restarts.
- instr and instr_valid are ignored outside RUN.

Decomposition:
- Package mips_run_pkg: state encoding (HOLD=2'd0, RUN=2'd1, HALTED=2'd2, TIMEOUT=2'd3) and the HALT_INSTR default constant.
- One sub-module: sat_counter (parameter WIDTH; ports clk, reset, clr, inc, q). Instantiated for cycle_count, instr_count and stall_cnt.
- FSM and halt logic stay in mips_run_ctrl.

Test Plan:
- Reset high 3 cycles, then low; instr_valid=0, pc incrementing by 4 -> core_reset high exactly 2 cycles after the reset drop; running=1 on the 3rd cycle; cycle_count=0 in the first RUN cycle.
- RUN, instr_valid=1 with instr=32'h2008_0001 for 10 cycles, then instr=32'h1000_ffff at pc=32'h0000_3028 -> done=1, halt_pc=32'h0000_3028, instr_count=11, core_en=0, counters frozen over 20 further cycles.
- RUN, pc held at 32'h0000_3010 with no halt word, STALL_LIMIT=4 -> done=1 after 4 equal-PC cycles; halt_pc=32'h0000_3010.
- MAX_CYCLES=16, pc always changing -> timeout=1 when cycle_count=15; done=0; state TIMEOUT holds.
- MAX_CYCLES=16, halt word on the cycle where cycle_count=15 -> done=1, timeout=0.
- Assert reset for 1 cycle while in RUN with cycle_count=7 -> all outputs return to reset values; core_reset high for 2 cycles; counting restarts from 0.
